// File: rtl/bcd_pkg.sv
// BCD digit type, digit limit and load-validation helper shared by the counter files.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;

    // True when the digit is a legal value for a position whose ceiling is lim.
    function automatic logic is_valid_bcd(bcd_digit_t d, bcd_digit_t lim);
        return (d <= lim);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit 0..LIMIT with clear/load/hold/up/down and roll-over flags.
// Latency: q_o updates on the rising edge after a request; roll flags are combinational.
// Backpressure: hold_i freezes the digit; roll flags still report the pending roll.
//
// Ports: clk_i/rst_i clock and async reset; up_i/down_i step requests; hold_i freeze;
//        clr_i sync clear; ld_i/ld_val_i parallel load; q_o digit value;
//        roll_up_o = stepping up from LIMIT; roll_dn_o = stepping down from 0.
module bcd_digit
    import bcd_pkg::*;
#(
    parameter bcd_digit_t LIMIT = BCD_DIGIT_MAX
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       hold_i,
    input  logic       clr_i,
    input  logic       ld_i,
    input  bcd_digit_t ld_val_i,
    output bcd_digit_t q_o,
    output logic       roll_up_o,
    output logic       roll_dn_o
);

    bcd_digit_t q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (clr_i) begin
            q <= '0;
        end else if (ld_i) begin
            q <= ld_val_i;
        end else if (hold_i) begin
            q <= q;
        end else if (up_i) begin
            q <= (q == LIMIT) ? bcd_digit_t'(0) : bcd_digit_t'(q + 4'd1);
        end else if (down_i) begin
            q <= (q == '0) ? LIMIT : bcd_digit_t'(q - 4'd1);
        end
    end

    assign q_o       = q;
    assign roll_up_o = up_i & (q == LIMIT);
    assign roll_dn_o = down_i & (q == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with top-digit limit, wrap/saturate, clear and validated load.
// Latency: count and load_err_o update one edge after the request; carry/borrow/at_zero are combinational.
// Backpressure: stop_i, clear_i or load_i block counting and force carry_o/borrow_o low.
//
// Ports: clk_i/rst_i clock and async active-high reset; inc_i/dec_i step requests;
//        stop_i hold; clear_i sync clear; load_i/load_val_i parallel load (digit 0 in [3:0]);
//        digits_o count; carry_o/borrow_o same-cycle roll-out for chaining;
//        at_zero_o count is zero; load_err_o one-cycle pulse after a rejected load.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int TOP_DIGIT_MAX = 9,
    parameter bit WRAP          = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    input  logic                    stop_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS*4-1:0] load_val_i,
    output logic [NUM_DIGITS*4-1:0] digits_o,
    output logic                    carry_o,
    output logic                    borrow_o,
    output logic                    at_zero_o,
    output logic                    load_err_o
);

    localparam bcd_digit_t TOP_LIM = bcd_digit_t'(TOP_DIGIT_MAX);

    logic inc_acc;
    logic dec_acc;
    logic load_ok;
    logic load_bad;
    logic sat_hold;
    logic digit_hold;
    logic load_err_q;

    // Any higher-priority request, or both directions at once, cancels the step.
    assign inc_acc = inc_i & ~dec_i & ~stop_i & ~clear_i & ~load_i;
    assign dec_acc = dec_i & ~inc_i & ~stop_i & ~clear_i & ~load_i;

    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!is_valid_bcd(load_val_i[4*k +: 4],
                              (k == NUM_DIGITS-1) ? TOP_LIM : BCD_DIGIT_MAX)) begin
                load_ok = 1'b0;
            end
        end
    end

    assign load_bad = load_i & ~clear_i & ~load_ok;

    // When saturating, the roll-out of the top digit still reports carry/borrow,
    // but every digit is frozen so the count stays at MAX or zero.
    assign sat_hold   = ~WRAP & (carry_o | borrow_o);
    assign digit_hold = stop_i | (load_i & ~load_ok) | sat_hold;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic up_en;
        logic dn_en;
        logic roll_up;
        logic roll_dn;

        // Each roll flag already includes its own enable, so the previous
        // digit's roll flag equals the AND of all lower roll flags.
        if (k == 0) begin : g_lsd
            assign up_en = inc_acc;
            assign dn_en = dec_acc;
        end else begin : g_upper
            assign up_en = g_digit[k-1].roll_up;
            assign dn_en = g_digit[k-1].roll_dn;
        end

        bcd_digit #(
            .LIMIT ((k == NUM_DIGITS-1) ? TOP_LIM : BCD_DIGIT_MAX)
        ) u_digit (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .up_i      (up_en),
            .down_i    (dn_en),
            .hold_i    (digit_hold),
            .clr_i     (clear_i),
            .ld_i      (load_i & load_ok),
            .ld_val_i  (load_val_i[4*k +: 4]),
            .q_o       (digits_o[4*k +: 4]),
            .roll_up_o (roll_up),
            .roll_dn_o (roll_dn)
        );
    end

    assign carry_o   = g_digit[NUM_DIGITS-1].roll_up;
    assign borrow_o  = g_digit[NUM_DIGITS-1].roll_dn;
    assign at_zero_o = (digits_o == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_bad;
        end
    end

    assign load_err_o = load_err_q;

endmodule
